// File: rtl/fifo_packer_pkg.sv
// fifo_packer_pkg: shared sizing and lane-mask helpers for the FIFO word packer.
package fifo_packer_pkg;

  // Accumulator count must hold 0..RATIO inclusive.
  function automatic int unsigned cnt_width(input int unsigned ratio);
    return $clog2(ratio) + 1;
  endfunction

  // Keep-mask helper: lane is populated when it lies below the word count.
  function automatic logic lane_en(input int unsigned lane, input int unsigned count);
    return lane < count;
  endfunction

endpackage

// File: rtl/fifo_packer_timer.sv
// fifo_packer_timer: idle-flush timeout counter, built only with FIFO_PACKER_TIMEOUT_EN.
module fifo_packer_timer #(
  parameter int unsigned LGTIMEOUT = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_timeout
);

  logic [LGTIMEOUT-1:0] timer;

  // Count idle cycles; wrap to zero when the terminal value is reached.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      timer <= '0;
    end else if (timer == '1) begin
      timer <= '0;
    end else begin
      timer <= timer + LGTIMEOUT'(1);
    end
  end

  assign o_timeout = (timer == '1) && !i_clear;

endmodule

// File: rtl/fifo_packer.sv
// fifo_packer: packs RATIO upstream FIFO words into one output beat.
// Optional idle-flush timer enabled by defining FIFO_PACKER_TIMEOUT_EN.
module fifo_packer
  import fifo_packer_pkg::*;
#(
  parameter int unsigned BW        = 8,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned LGTIMEOUT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_fifo_empty,
  input  logic [BW-1:0]         i_fifo_data,
  output logic                  o_fifo_rd,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [RATIO*BW-1:0]   o_data,
  output logic [RATIO-1:0]      o_keep,
  output logic                  o_last
);

  localparam int unsigned CW = cnt_width(RATIO);
  localparam logic [CW-1:0] RATIO_C  = CW'(RATIO);
  localparam logic [CW-1:0] RATIO_M1 = CW'(RATIO - 1);

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("fifo_packer: RATIO must be a power of two, at least 2");
  end
  if (LGTIMEOUT < 2) begin : g_bad_timeout
    $error("fifo_packer: LGTIMEOUT must be at least 2");
  end

  logic [CW-1:0]       cnt;
  logic [RATIO*BW-1:0] acc;
  logic                flush_pend;

  logic                slot_free;
  logic                timeout;
  logic                carry;
  logic                flush_req;
  logic                load;
  logic [CW-1:0]       beat_cnt;
  logic [RATIO*BW-1:0] beat_data;
  logic [RATIO-1:0]    beat_keep;

  assign slot_free = !o_valid || i_ready;
  assign o_fifo_rd = !i_fifo_empty && !i_reset && ((cnt < RATIO_M1) || slot_free);

`ifdef FIFO_PACKER_TIMEOUT_EN
  fifo_packer_timer #(
    .LGTIMEOUT (LGTIMEOUT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (o_fifo_rd || (cnt == '0)),
    .o_timeout (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Candidate beat: accumulator plus any word read this cycle, masked to the word count.
  always_comb begin
    // A full accumulator emits as-is; a word read alongside goes to lane 0 of the next beat.
    carry     = o_fifo_rd && (cnt == RATIO_C);
    beat_cnt  = (cnt == RATIO_C) ? cnt : cnt + CW'(o_fifo_rd);
    flush_req = (i_flush || timeout || flush_pend) && (beat_cnt != '0);
    load      = slot_free && (flush_req || (beat_cnt == RATIO_C));
    beat_data = '0;
    beat_keep = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (lane_en(k, 32'(beat_cnt))) begin
        beat_keep[k] = 1'b1;
        beat_data[k*BW +: BW] = (o_fifo_rd && !carry && (k == 32'(cnt))) ? i_fifo_data
                                                                           : acc[k*BW +: BW];
      end
    end
  end

  // Accumulator, pending flush and output register updates.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt        <= '0;
      acc        <= '0;
      flush_pend <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_keep     <= '0;
      o_last     <= 1'b0;
    end else begin
      if (load) begin
        o_valid    <= 1'b1;
        o_data     <= beat_data;
        o_keep     <= beat_keep;
        o_last     <= flush_req;
        cnt        <= {{(CW-1){1'b0}}, carry};
        flush_pend <= 1'b0;
      end else begin
        if (i_ready) begin
          o_valid <= 1'b0;
        end
        cnt        <= beat_cnt;
        flush_pend <= flush_req;
      end
      for (int unsigned k = 0; k < RATIO; k++) begin
        if (o_fifo_rd && (carry ? (k == 0) : (k == 32'(cnt)))) begin
          acc[k*BW +: BW] <= i_fifo_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_packer.sv
// tb_fifo_packer: directed self-checking bench for fifo_packer (BW=8, RATIO=4, LGTIMEOUT=3).
module tb_fifo_packer;

  logic        clk = 1'b0;
  logic        i_reset, i_fifo_empty, i_flush, i_ready;
  logic [7:0]  i_fifo_data;
  logic        o_fifo_rd, o_valid, o_last;
  logic [31:0] o_data;
  logic [3:0]  o_keep;

  logic [7:0]  q[$];
  logic [31:0] cap_data[$];
  logic [3:0]  cap_keep[$];
  logic        cap_last[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_packer #(
    .BW        (8),
    .RATIO     (4),
    .LGTIMEOUT (3)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_rd    (o_fifo_rd),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_keep       (o_keep),
    .o_last       (o_last)
  );

  task automatic drive_fifo();
    i_fifo_empty = (q.size() == 0);
    i_fifo_data  = (q.size() == 0) ? 8'h00 : q[0];
  endtask

  task automatic push_word(input logic [7:0] w);
    q.push_back(w);
    drive_fifo();
  endtask

  task automatic clear_caps();
    cap_data.delete();
    cap_keep.delete();
    cap_last.delete();
  endtask

  // One clock: sample handshakes at negedge, advance upstream FIFO model after posedge.
  task automatic tick();
    logic rd_seen;
    @(negedge clk);
    rd_seen = o_fifo_rd;
    if (o_valid && i_ready) begin
      cap_data.push_back(o_data);
      cap_keep.push_back(o_keep);
      cap_last.push_back(o_last);
    end
    @(posedge clk);
    #1;
    if (rd_seen && q.size() > 0) void'(q.pop_front());
    drive_fifo();
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_flush = 1'b0; i_ready = 1'b1;
    q.delete();
    push_word(8'h77);
    tick(); tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 00000000", o_data); end
    n_cmp++; if (o_keep !== 4'h0) begin n_err++; $display("FAIL reset_keep: got %b want 0000", o_keep); end
    n_cmp++; if (o_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", o_last); end
    n_cmp++; if (o_fifo_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %b want 0", o_fifo_rd); end
    q.delete();
    drive_fifo();
    i_reset = 1'b0;
    tick(); tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", o_valid); end
    clear_caps();
  endtask

  task automatic test_full_beat();
    clear_caps();
    i_ready = 1'b1;
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    tick(); tick(); tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL full_early: got %b want 0", o_valid); end
    tick();
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL full_valid: got %b want 1", o_valid); end
    n_cmp++; if (o_data !== 32'h44332211) begin n_err++; $display("FAIL full_data: got %h want 44332211", o_data); end
    n_cmp++; if (o_keep !== 4'b1111) begin n_err++; $display("FAIL full_keep: got %b want 1111", o_keep); end
    n_cmp++; if (o_last !== 1'b0) begin n_err++; $display("FAIL full_last: got %b want 0", o_last); end
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL full_drop: got %b want 0", o_valid); end
    n_cmp++; if (cap_data.size() !== 1) begin n_err++; $display("FAIL full_count: got %0d want 1", cap_data.size()); end
  endtask

  task automatic test_back_to_back_stall();
    clear_caps();
    i_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    for (int i = 0; i < 7; i++) tick();
    n_cmp++; if (o_fifo_rd !== 1'b0) begin n_err++; $display("FAIL stall_rd: got %b want 0", o_fifo_rd); end
    n_cmp++; if (q.size() !== 1) begin n_err++; $display("FAIL stall_left: got %0d want 1", q.size()); end
    tick();
    n_cmp++; if (o_valid !== 1'b1 || o_data !== 32'h04030201) begin
      n_err++; $display("FAIL stall_hold: got v=%b %h want v=1 04030201", o_valid, o_data);
    end
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (cap_data.size() !== 2) begin n_err++; $display("FAIL stall_count: got %0d want 2", cap_data.size()); end
    else begin
      n_cmp++; if (cap_data[0] !== 32'h04030201) begin n_err++; $display("FAIL stall_beat0: got %h want 04030201", cap_data[0]); end
      n_cmp++; if (cap_data[1] !== 32'h08070605) begin n_err++; $display("FAIL stall_beat1: got %h want 08070605", cap_data[1]); end
      n_cmp++; if (cap_keep[1] !== 4'b1111 || cap_last[1] !== 1'b0) begin
        n_err++; $display("FAIL stall_meta1: got keep=%b last=%b want 1111 0", cap_keep[1], cap_last[1]);
      end
    end
  endtask

  task automatic test_flush();
    clear_caps();
    i_ready = 1'b1;
    push_word(8'hAA); push_word(8'hBB);
    tick(); tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL flush_valid: got %b want 1", o_valid); end
    n_cmp++; if (o_data !== 32'h0000BBAA) begin n_err++; $display("FAIL flush_data: got %h want 0000bbaa", o_data); end
    n_cmp++; if (o_keep !== 4'b0011) begin n_err++; $display("FAIL flush_keep: got %b want 0011", o_keep); end
    n_cmp++; if (o_last !== 1'b1) begin n_err++; $display("FAIL flush_last: got %b want 1", o_last); end
    tick();
  endtask

  task automatic test_flush_on_fill();
    clear_caps();
    i_ready = 1'b1;
    push_word(8'hC1); push_word(8'hC2); push_word(8'hC3); push_word(8'hC4);
    tick(); tick(); tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    n_cmp++; if (o_data !== 32'hC4C3C2C1) begin n_err++; $display("FAIL fillflush_data: got %h want c4c3c2c1", o_data); end
    n_cmp++; if (o_keep !== 4'b1111 || o_last !== 1'b1) begin
      n_err++; $display("FAIL fillflush_meta: got keep=%b last=%b want 1111 1", o_keep, o_last);
    end
    tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    tick(); tick();
    n_cmp++; if (cap_data.size() !== 1) begin n_err++; $display("FAIL empty_flush: got %0d beats want 1", cap_data.size()); end
  endtask

  task automatic test_flush_pending();
    clear_caps();
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'hA0 + 8'(i));
    for (int i = 0; i < 5; i++) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    tick();
    n_cmp++; if (o_keep !== 4'b1111 || o_last !== 1'b0) begin
      n_err++; $display("FAIL pend_hold: got keep=%b last=%b want 1111 0", o_keep, o_last);
    end
    i_ready = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (cap_data.size() !== 2) begin n_err++; $display("FAIL pend_count: got %0d want 2", cap_data.size()); end
    else begin
      n_cmp++; if (cap_data[0] !== 32'hA3A2A1A0) begin n_err++; $display("FAIL pend_beat0: got %h want a3a2a1a0", cap_data[0]); end
      n_cmp++; if (cap_data[1] !== 32'h000000A4 || cap_keep[1] !== 4'b0001 || cap_last[1] !== 1'b1) begin
        n_err++; $display("FAIL pend_beat1: got %h keep=%b last=%b want 000000a4 0001 1", cap_data[1], cap_keep[1], cap_last[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_caps();
    i_ready = 1'b0;
    push_word(8'hEE); push_word(8'hEF); push_word(8'hF0);
    tick(); tick(); tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    i_ready = 1'b1;
    push_word(8'h01); push_word(8'h02); push_word(8'h03); push_word(8'h04);
    for (int i = 0; i < 5; i++) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    tick(); tick();
    n_cmp++; if (cap_data.size() !== 1) begin n_err++; $display("FAIL rstmid_count: got %0d want 1", cap_data.size()); end
    else begin
      n_cmp++; if (cap_data[0] !== 32'h04030201 || cap_keep[0] !== 4'b1111) begin
        n_err++; $display("FAIL rstmid_beat: got %h keep=%b want 04030201 1111", cap_data[0], cap_keep[0]);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    clear_caps();
    i_ready = 1'b1;
    push_word(8'h5A);
`ifdef FIFO_PACKER_TIMEOUT_EN
    n = 0;
    while (o_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    n_cmp++; if (n !== 9) begin n_err++; $display("FAIL timeout_delay: got %0d cycles want 9", n); end
    n_cmp++; if (o_data !== 32'h0000005A || o_keep !== 4'b0001 || o_last !== 1'b1) begin
      n_err++; $display("FAIL timeout_beat: got %h keep=%b last=%b want 0000005a 0001 1", o_data, o_keep, o_last);
    end
    tick();
`else
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (o_valid === 1'b1) n++;
    end
    n_cmp++; if (n !== 0) begin n_err++; $display("FAIL notimer_beat: got %0d valid cycles want 0", n); end
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    n_cmp++; if (o_data !== 32'h0000005A || o_keep !== 4'b0001 || o_last !== 1'b1) begin
      n_err++; $display("FAIL notimer_flush: got %h keep=%b last=%b want 0000005a 0001 1", o_data, o_keep, o_last);
    end
    tick();
`endif
  endtask

  initial begin
    i_reset = 1'b1; i_flush = 1'b0; i_ready = 1'b0;
    i_fifo_empty = 1'b1; i_fifo_data = 8'h00;
    test_reset();
    test_full_beat();
    test_back_to_back_stall();
    test_flush();
    test_flush_on_fill();
    test_flush_pending();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
